// File: rtl/serial_async_pkg.sv
// Shared framing helpers for the asynchronous serial transmitter and receiver:
// state encoding, bit-period calculation and parity.
package serial_async_pkg;

  typedef logic [2:0] t_tx_state;

  localparam t_tx_state StReady    = 3'd0;
  localparam t_tx_state StStart    = 3'd1;
  localparam t_tx_state StData     = 3'd2;
  localparam t_tx_state StParity   = 3'd3;
  localparam t_tx_state StStop     = 3'd4;

  // Widest word the parity helper accepts; narrower words are zero-extended.
  localparam int unsigned MaxWordBits = 64;

  function automatic int unsigned bit_period(int unsigned main_clk_hz,
                                             int unsigned serial_clk_hz);
    return main_clk_hz / serial_clk_hz;
  endfunction

  // Even parity makes the total count of ones (data + parity) even.
  function automatic logic parity(logic [MaxWordBits-1:0] data, logic even);
    return (^data) ^ ~even;
  endfunction

endpackage

// File: rtl/serial_async_tx_if.sv
// Word handshake and serial line of the asynchronous transmitter.
interface serial_async_tx_if #(
  parameter int unsigned BITS = 8
) ();

  logic            in_enable;
  logic [BITS-1:0] in_parallel;
  logic            out_ready;
  logic            out_next_word;
  logic            out_serial;

  modport master (
    output in_enable,
    output in_parallel,
    input  out_ready,
    input  out_next_word,
    input  out_serial
  );

  modport slave (
    input  in_enable,
    input  in_parallel,
    output out_ready,
    output out_next_word,
    output out_serial
  );

endinterface

// File: rtl/serial_bit_tick.sv
// Bit-period counter: tick_o is high on the last cycle of every PERIOD-cycle bit.
module serial_bit_tick #(
  parameter int unsigned PERIOD = 8
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned   CntW = $clog2(PERIOD) + 1;
  localparam logic [CntW-1:0] Last = CntW'(PERIOD - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == Last);

  always_comb begin
    if (clear_i || tick_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_async_tx.sv
// UART-style transmitter: start, data, optional parity and stop sections, each bit
// held for one bit period; back-to-back frames when in_enable stays high.
module serial_async_tx
  import serial_async_pkg::*;
#(
  parameter int unsigned MAIN_CLK_HZ   = 50_000_000,
  parameter int unsigned SERIAL_CLK_HZ = 9_600,
  parameter logic        SERIAL_START  = 1'b0,
  parameter logic        SERIAL_STOP   = 1'b1,
  parameter int unsigned BITS          = 8,
  parameter int unsigned START_BITS    = 1,
  parameter int unsigned PARITY_BITS   = 0,
  parameter int unsigned STOP_BITS     = 1,
  parameter logic        LOWBIT_FIRST  = 1'b1,
  parameter logic        EVEN_PARITY   = 1'b1
) (
  input logic               in_clk,
  input logic               in_rst,
  serial_async_tx_if.slave  bus
);

  localparam int unsigned T      = bit_period(MAIN_CLK_HZ, SERIAL_CLK_HZ);
  localparam int unsigned MaxAB  = (BITS > START_BITS) ? BITS : START_BITS;
  localparam int unsigned MaxCD  = (STOP_BITS > PARITY_BITS) ? STOP_BITS : PARITY_BITS;
  localparam int unsigned MaxSec = (MaxAB > MaxCD) ? MaxAB : MaxCD;
  localparam int unsigned CntW   = $clog2(MaxSec) + 1;
  localparam t_tx_state FirstSec = (START_BITS != 0) ? StStart : StData;

  t_tx_state       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d, last_idx;
  logic [BITS-1:0] data_q, data_d;
  logic            serial_q, serial_d;
  logic            next_word_q, next_word_d;
  logic            tick, can_latch;

  function automatic int unsigned sec_len(t_tx_state s);
    case (s)
      StStart:  return START_BITS;
      StData:   return BITS;
      StParity: return PARITY_BITS;
      StStop:   return STOP_BITS;
      default:  return 0;
    endcase
  endfunction

  // Empty sections are skipped here, so they cost no cycles.
  function automatic t_tx_state sec_after(t_tx_state s);
    case (s)
      StStart:  return StData;
      StData:   return (PARITY_BITS != 0) ? StParity : ((STOP_BITS != 0) ? StStop : StReady);
      StParity: return (STOP_BITS != 0) ? StStop : StReady;
      default:  return StReady;
    endcase
  endfunction

  function automatic logic line_level(t_tx_state s, logic [CntW-1:0] idx,
                                      logic [BITS-1:0] word);
    logic [BITS-1:0] shifted;
    logic            lvl;
    case (s)
      StStart: lvl = SERIAL_START;
      StData: begin
        shifted = LOWBIT_FIRST ? (word >> idx) : (word << idx);
        lvl     = LOWBIT_FIRST ? shifted[0] : shifted[BITS-1];
      end
      StParity: lvl = parity(MaxWordBits'(word), EVEN_PARITY);
      default:  lvl = SERIAL_STOP;
    endcase
    return lvl;
  endfunction

  serial_bit_tick #(
    .PERIOD (T)
  ) u_tick (
    .in_clk  (in_clk),
    .in_rst  (in_rst),
    .clear_i (state_q == StReady),
    .tick_o  (tick)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    data_d      = data_q;
    next_word_d = 1'b0;
    can_latch   = 1'b0;
    last_idx    = CntW'(sec_len(state_q) - 1);

    if (state_q == StReady) begin
      can_latch = 1'b1;
    end else if (tick) begin
      if (cnt_q == last_idx) begin
        state_d   = sec_after(state_q);
        cnt_d     = '0;
        can_latch = (state_d == StReady);
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    if (can_latch && bus.in_enable) begin
      data_d      = bus.in_parallel;
      next_word_d = 1'b1;
      state_d     = FirstSec;
      cnt_d       = '0;
    end

    // The line register always shows the bit selected by the next state.
    serial_d = line_level(state_d, cnt_d, data_d);
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= StReady;
      cnt_q       <= '0;
      data_q      <= '0;
      serial_q    <= SERIAL_STOP;
      next_word_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      serial_q    <= serial_d;
      next_word_q <= next_word_d;
    end
  end

  assign bus.out_ready     = (state_q == StReady);
  assign bus.out_next_word = next_word_q;
  assign bus.out_serial    = serial_q;

endmodule

// File: tb/tb_serial_async_tx.sv
// Three transmitter configurations driven in lockstep and compared every cycle
// against a frame-list reference model.
module tb_serial_async_tx;

  localparam int T = 8;
  localparam int NDut = 3;

  logic in_clk = 1'b0;
  logic in_rst;
  always #5 in_clk = ~in_clk;

  serial_async_tx_if #(.BITS(8)) bus_a ();
  serial_async_tx_if #(.BITS(8)) bus_b ();
  serial_async_tx_if #(.BITS(8)) bus_c ();

  // 8N1, LSB first
  serial_async_tx #(
    .MAIN_CLK_HZ(80), .SERIAL_CLK_HZ(10)
  ) u_dut_a (
    .in_clk (in_clk), .in_rst (in_rst), .bus (bus_a.slave)
  );

  // 8E1, LSB first
  serial_async_tx #(
    .MAIN_CLK_HZ(80), .SERIAL_CLK_HZ(10), .PARITY_BITS(1), .EVEN_PARITY(1'b1)
  ) u_dut_b (
    .in_clk (in_clk), .in_rst (in_rst), .bus (bus_b.slave)
  );

  // two start bits, MSB first, odd parity, two stop bits
  serial_async_tx #(
    .MAIN_CLK_HZ(80), .SERIAL_CLK_HZ(10), .START_BITS(2), .PARITY_BITS(1),
    .STOP_BITS(2), .LOWBIT_FIRST(1'b0), .EVEN_PARITY(1'b0)
  ) u_dut_c (
    .in_clk (in_clk), .in_rst (in_rst), .bus (bus_c.slave)
  );

  int cfg_start[NDut] = '{1, 1, 2};
  int cfg_par[NDut]   = '{0, 1, 1};
  int cfg_stop[NDut]  = '{1, 1, 2};
  bit cfg_lsb[NDut]   = '{1'b1, 1'b1, 1'b0};
  bit cfg_even[NDut]  = '{1'b1, 1'b1, 1'b0};

  logic [2:0] o_ser, o_rdy, o_nw;
  assign o_ser = {bus_c.out_serial, bus_b.out_serial, bus_a.out_serial};
  assign o_rdy = {bus_c.out_ready, bus_b.out_ready, bus_a.out_ready};
  assign o_nw  = {bus_c.out_next_word, bus_b.out_next_word, bus_a.out_next_word};

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  logic       en_drv;
  logic [7:0] word_drv;

  bit          m_busy[NDut];
  bit          m_nw[NDut];
  int          m_pos[NDut];
  int          m_len[NDut];
  logic [31:0] m_bits[NDut];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Frame as a list of line levels, bit 0 sent first.
  function automatic logic [31:0] build_frame(int d, logic [7:0] w);
    logic [31:0] f;
    int n;
    logic p;
    f = '0;
    n = 0;
    for (int i = 0; i < cfg_start[d]; i++) begin f[n] = 1'b0; n++; end
    for (int i = 0; i < 8; i++) begin
      f[n] = cfg_lsb[d] ? w[i] : w[7-i];
      n++;
    end
    p = ^w;
    if (!cfg_even[d]) p = ~p;
    for (int i = 0; i < cfg_par[d]; i++) begin f[n] = p; n++; end
    for (int i = 0; i < cfg_stop[d]; i++) begin f[n] = 1'b1; n++; end
    return f;
  endfunction

  task automatic model_start(input int d);
    m_busy[d] = 1'b1;
    m_pos[d]  = 0;
    m_len[d]  = cfg_start[d] + 8 + cfg_par[d] + cfg_stop[d];
    m_bits[d] = build_frame(d, word_drv);
    m_nw[d]   = 1'b1;
  endtask

  task automatic model_edge();
    for (int d = 0; d < NDut; d++) begin
      m_nw[d] = 1'b0;
      if (!m_busy[d]) begin
        if (en_drv) model_start(d);
      end else begin
        m_pos[d]++;
        if (m_pos[d] == m_len[d] * T) begin
          if (en_drv) model_start(d);
          else m_busy[d] = 1'b0;
        end
      end
    end
  endtask

  task automatic compare_all();
    logic exp_ser;
    for (int d = 0; d < NDut; d++) begin
      exp_ser = m_busy[d] ? m_bits[d][m_pos[d] / T] : 1'b1;
      chk($sformatf("serial dut%0d", d), 32'(o_ser[d]), 32'(exp_ser));
      chk($sformatf("ready dut%0d", d), 32'(o_rdy[d]), 32'(!m_busy[d]));
      chk($sformatf("next_word dut%0d", d), 32'(o_nw[d]), 32'(m_nw[d]));
    end
  endtask

  task automatic drive(input logic en, input logic [7:0] w);
    en_drv   = en;
    word_drv = w;
    bus_a.in_enable = en; bus_a.in_parallel = w;
    bus_b.in_enable = en; bus_b.in_parallel = w;
    bus_c.in_enable = en; bus_c.in_parallel = w;
  endtask

  task automatic cycle();
    @(posedge in_clk);
    model_edge();
    @(negedge in_clk);
    cyc++;
    compare_all();
  endtask

  task automatic model_reset();
    for (int d = 0; d < NDut; d++) begin
      m_busy[d] = 1'b0;
      m_nw[d]   = 1'b0;
      m_pos[d]  = 0;
    end
  endtask

  // Called at a falling edge; the outputs must drop to idle without a clock edge.
  task automatic async_reset();
    in_rst = 1'b1;
    drive(1'b0, 8'h00);
    model_reset();
    #1;
    compare_all();
    @(posedge in_clk);
    @(negedge in_clk);
    compare_all();
    in_rst = 1'b0;
  endtask

  task automatic one_frame(input logic [7:0] w, input int idle);
    drive(1'b1, w);
    cycle();
    drive(1'b0, 8'($urandom));
    repeat (idle) cycle();
  endtask

  initial begin
    in_rst = 1'b1;
    drive(1'b0, 8'h00);
    model_reset();
    repeat (3) @(negedge in_clk);
    compare_all();
    in_rst = 1'b0;
    repeat (2) cycle();

    one_frame(8'hA5, 110);
    one_frame(8'h07, 110);
    one_frame(8'h80, 110);

    // enable held: frames run back to back, second word presented after the first latch
    drive(1'b1, 8'h55);
    cycle();
    drive(1'b1, 8'h0F);
    repeat (250) cycle();
    drive(1'b0, 8'h00);
    repeat (110) cycle();

    // reset in the middle of a frame, then a clean frame
    one_frame(8'hC3, 29);
    async_reset();
    repeat (3) cycle();
    one_frame(8'h3C, 110);

    // enable dropped and word changed mid-frame
    drive(1'b1, 8'h00);
    cycle();
    drive(1'b0, 8'hFF);
    repeat (110) cycle();

    // sparse random requests with random data every cycle
    repeat (1200) begin
      drive($urandom_range(0, 15) == 0, 8'($urandom));
      cycle();
    end
    // long stretches of continuous enable
    repeat (600) begin
      drive($urandom_range(0, 19) != 0, 8'($urandom));
      cycle();
    end
    drive(1'b0, 8'h00);
    repeat (110) cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
